// File: rtl/lsu_align.sv
// RV32I load/store alignment unit: turns byte-addressed loads/stores into
// word reads and read-modify-write word writes, splitting accesses that cross a word boundary.
module lsu_align #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-3:0] mem_ra,
   output logic [2:0]        mem_rm,
   input  logic [31:0]       mem_rd,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_wa,
   output logic [2:0]        mem_wm,
   output logic [31:0]       mem_wd
);
   localparam int WI_W = ADDR_W - 2;
   localparam logic [2:0] MODE_WORD = 3'b010;

   typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_e;

   state_e          state_q;
   logic            we_q, span_q, err_q;
   logic [2:0]      f3_q, size_q;
   logic [1:0]      off_q;
   logic [WI_W-1:0] w0_q, w1_q;
   logic [31:0]     wdata_q, buf0_q, buf1_q;

   // Request decode, evaluated on the accept cycle
   logic [2:0] size_d;
   logic       illegal_d, span_d;

   always_comb begin
      size_d = 3'd4;
      case (req_funct3[1:0])
         2'b00:   size_d = 3'd1;
         2'b01:   size_d = 3'd2;
         default: size_d = 3'd4;
      endcase
   end

   assign illegal_d = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                      (req_we && req_funct3[2]);
   assign span_d    = ({2'b00, req_addr[1:0]} + {1'b0, size_d}) > 4'd4;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               we_q    <= req_we;
               f3_q    <= req_funct3;
               size_q  <= size_d;
               off_q   <= req_addr[1:0];
               w0_q    <= req_addr[ADDR_W-1:2];
               w1_q    <= req_addr[ADDR_W-1:2] + {{(WI_W-1){1'b0}}, 1'b1};
               span_q  <= span_d;
               err_q   <= illegal_d;
               wdata_q <= req_wdata;
               state_q <= illegal_d ? RESP : RD0;
            end
            RD0: begin
               buf0_q  <= mem_rd;
               state_q <= span_q ? RD1 : (we_q ? WR0 : RESP);
            end
            RD1: begin
               buf1_q  <= mem_rd;
               state_q <= we_q ? WR0 : RESP;
            end
            WR0:     state_q <= span_q ? WR1 : RESP;
            WR1:     state_q <= RESP;
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Two-word window: loads shift it down, stores merge into it at the byte offset
   logic [63:0] win, st_data, st_mask, merged;
   logic [5:0]  sh;
   logic [31:0] ld_w, ld_ext;
   logic [7:0]  bmask_base, bmask;

   assign win     = {buf1_q, buf0_q};
   assign sh      = {1'b0, off_q, 3'b000};
   assign ld_w    = 32'(win >> sh);
   assign st_data = {32'h0, wdata_q} << sh;

   always_comb begin
      bmask_base = 8'h0F;
      case (size_q)
         3'd1:    bmask_base = 8'h01;
         3'd2:    bmask_base = 8'h03;
         default: bmask_base = 8'h0F;
      endcase
   end

   assign bmask = bmask_base << off_q;

   for (genvar b = 0; b < 8; b++) begin : g_mask
      assign st_mask[8*b +: 8] = {8{bmask[b]}};
   end

   assign merged = (win & ~st_mask) | (st_data & st_mask);

   always_comb begin
      ld_ext = ld_w;
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_w[7]}}, ld_w[7:0]};
         3'b001:  ld_ext = {{16{ld_w[15]}}, ld_w[15:0]};
         3'b100:  ld_ext = {24'h0, ld_w[7:0]};
         3'b101:  ld_ext = {16'h0, ld_w[15:0]};
         default: ld_ext = ld_w;
      endcase
   end

   assign req_ready  = !reset && (state_q == IDLE);
   assign resp_valid = !reset && (state_q == RESP);
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !err_q && !we_q) ? ld_ext : 32'h0;

   assign mem_rm = MODE_WORD;
   assign mem_wm = MODE_WORD;
   assign mem_ra = (state_q == RD1) ? w1_q : w0_q;
   assign mem_we = !reset && ((state_q == WR0) || (state_q == WR1));
   assign mem_wa = (state_q == WR1) ? w1_q : w0_q;
   assign mem_wd = (state_q == WR1) ? merged[63:32] : merged[31:0];
endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a behavioural word memory and hand-computed expectations.
module tb_lsu_align;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [7:0]  mem_ra, mem_wa;
   logic [2:0]  mem_rm, mem_wm;
   logic [31:0] mem_rd, mem_wd;
   logic        mem_we;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [256];
   int          wr_cnt;
   int          rv_cnt;
   logic [7:0]  wr_wa [8];
   logic [31:0] wr_wd [8];

   always #5 clk = ~clk;

   lsu_align #(.ADDR_W(10)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_ra(mem_ra), .mem_rm(mem_rm), .mem_rd(mem_rd),
      .mem_we(mem_we), .mem_wa(mem_wa), .mem_wm(mem_wm), .mem_wd(mem_wd)
   );

   assign mem_rd = mem[mem_ra];

   always @(posedge clk) begin
      if (mem_we) begin
         if (wr_cnt < 8) begin
            wr_wa[wr_cnt] = mem_wa;
            wr_wd[wr_cnt] = mem_wd;
         end
         wr_cnt = wr_cnt + 1;
         mem[mem_wa] = mem_wd;
      end
      if (resp_valid) rv_cnt = rv_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic err);
      int guard;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      wr_cnt     = 0;
      rv_cnt     = 0;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      rd  = 32'hx;
      err = 1'bx;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (resp_valid) begin
            rd  = resp_rdata;
            err = resp_err;
            break;
         end
      end
   endtask

   task automatic run(input string tag, input logic we, input logic [2:0] f3,
                      input logic [9:0] addr, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
      int          lat;
      logic [31:0] rd;
      logic        err;
      do_req(we, f3, addr, wd, lat, rd, err);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = '0;
      req_wdata  = '0;
      wr_cnt     = 0;
      rv_cnt     = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      repeat (3) @(negedge clk);

      chk("rst_ready", {31'h0, req_ready}, 32'h0);
      chk("rst_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_err", {31'h0, resp_err}, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_we", {31'h0, mem_we}, 32'h0);
      chk("rd_mode", {29'h0, mem_rm}, 32'h2);
      chk("wr_mode", {29'h0, mem_wm}, 32'h2);
      reset = 1'b0;
      #1 chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

      mem[0] = 32'h44332211;
      mem[1] = 32'h88776655;
      run("lb3",  1'b0, 3'b000, 10'd3, 32'h0, 2, 32'h00000044, 1'b0);
      run("lb7",  1'b0, 3'b000, 10'd7, 32'h0, 2, 32'hFFFFFF88, 1'b0);
      run("lbu7", 1'b0, 3'b100, 10'd7, 32'h0, 2, 32'h00000088, 1'b0);
      run("lhu6", 1'b0, 3'b101, 10'd6, 32'h0, 2, 32'h00008877, 1'b0);
      run("lw2",  1'b0, 3'b010, 10'd2, 32'h0, 3, 32'h66554433, 1'b0);
      run("lh3",  1'b0, 3'b001, 10'd3, 32'h0, 3, 32'h00005544, 1'b0);

      run("sh3", 1'b1, 3'b001, 10'd3, 32'h0000BEEF, 5, 32'h0, 1'b0);
      chk("sh3_nwr", wr_cnt, 2);
      chk("sh3_wa0", {24'h0, wr_wa[0]}, 32'd0);
      chk("sh3_wd0", wr_wd[0], 32'hEF332211);
      chk("sh3_wa1", {24'h0, wr_wa[1]}, 32'd1);
      chk("sh3_wd1", wr_wd[1], 32'h887766BE);

      run("sb5", 1'b1, 3'b000, 10'd5, 32'h123456AB, 3, 32'h0, 1'b0);
      chk("sb5_nwr", wr_cnt, 1);
      chk("sb5_wd", wr_wd[0], 32'h8877ABBE);

      run("sw1020", 1'b1, 3'b010, 10'd1020, 32'h00123456, 3, 32'h0, 1'b0);
      chk("sw1020_nwr", wr_cnt, 1);
      chk("sw1020_wa", {24'h0, wr_wa[0]}, 32'd255);
      chk("sw1020_wd", wr_wd[0], 32'h00123456);

      mem[255] = 32'hAABBCCDD;
      mem[0]   = 32'h44332211;
      run("lw1023", 1'b0, 3'b010, 10'd1023, 32'h0, 3, 32'h332211AA, 1'b0);

      run("err_f3_011", 1'b0, 3'b011, 10'd0, 32'h0, 1, 32'h0, 1'b1);
      chk("err_f3_011_nwr", wr_cnt, 0);
      run("err_sbu", 1'b1, 3'b100, 10'd4, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
      chk("err_sbu_nwr", wr_cnt, 0);

      // Spanning store aborted by reset while the second read is in progress
      while (!req_ready) @(negedge clk);
      wr_cnt     = 0;
      rv_cnt     = 0;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b001;
      req_addr   = 10'd3;
      req_wdata  = 32'h0000CAFE;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy", {31'h0, req_ready}, 32'h0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_rst_ready", {31'h0, req_ready}, 32'h0);
      reset = 1'b0;
      #1 chk("abort_ready", {31'h0, req_ready}, 32'h1);
      repeat (3) @(negedge clk);
      chk("abort_nwr", wr_cnt, 0);
      chk("abort_nresp", rv_cnt, 0);
      chk("abort_mem0", mem[0], 32'h44332211);
      chk("abort_mem1", mem[1], 32'h8877ABBE);
      run("lb1_after", 1'b0, 3'b000, 10'd1, 32'h0, 2, 32'h00000022, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
